// File: rtl/muldiv_if.sv
// Launch/complete bus between the core controller and the multiply/divide unit.
//
// Handshake: the controller raises `start` for one cycle with `op`, `srca` and
// `srcb` valid. The unit takes it on a rising edge only when it is idle or
// finishing (the cycle before `done`). Operands are captured at that edge and
// may change afterwards. `busy` is high from the accepting edge until the edge
// that raises `done`. `done` is a one-cycle pulse and `result` is valid with
// it; `result` then holds until the next completion. A `start` seen while the
// unit is computing is dropped, not queued.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;

    modport master (output start, op, srca, srcb, input busy, done, result);
    modport slave  (input start, op, srca, srcb, output busy, done, result);
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring
// divide, magnitude arithmetic with a final sign fix-up cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    muldiv_if.slave    bus,
    output logic [1:0] dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               neg_res, spec_q;
    // Multiply: {product high, multiplier/product low}. Divide: {remainder, quotient}.
    // Special cases park their preset result in the low half.
    logic [2*WIDTH-1:0] acc;

    logic               accept, a_signed, b_signed, neg_a, neg_b;
    logic               b_zero, sgn_ovf, special, neg_nxt;
    logic [WIDTH-1:0]   srca_mag, srcb_mag, preset;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH+1:0]   div_diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH-1:0]   quot_fix, rem_fix, fix_val;

    assign dbg_state = state;
    assign bus.busy  = (state != IDLE);

    // Launch decode: acceptance, operand signedness, magnitudes and special cases.
    always_comb begin
        accept   = bus.start && (state == IDLE || state == FIX);
        a_signed = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
        b_signed = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
        neg_a    = a_signed && bus.srca[WIDTH-1];
        neg_b    = b_signed && bus.srcb[WIDTH-1];
        srca_mag = neg_a ? -bus.srca : bus.srca;
        srcb_mag = neg_b ? -bus.srcb : bus.srcb;
        b_zero   = (bus.srcb == '0);
        sgn_ovf  = ((bus.op == 3'd4) || (bus.op == 3'd6)) &&
                   (bus.srca == MIN_NEG) && (bus.srcb == '1);
        special  = bus.op[2] && (b_zero || sgn_ovf);
        // op[1] separates rem/remu from div/divu within the divide group.
        if (b_zero) begin
            preset = bus.op[1] ? bus.srca : '1;
        end else begin
            preset = bus.op[1] ? '0 : bus.srca;
        end
        // Result sign: product/quotient follow the sign mismatch, remainder follows the dividend.
        if (bus.op[2] && bus.op[0]) begin
            neg_nxt = 1'b0;
        end else if (bus.op[2] && bus.op[1]) begin
            neg_nxt = neg_a;
        end else begin
            neg_nxt = neg_a ^ neg_b;
        end
    end

    // One iteration step for each algorithm plus the fix-up result selection.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mag_a};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
        // The shifted partial remainder needs WIDTH+1 bits before the trial subtract.
        div_diff = {1'b0, acc[2*WIDTH-1:WIDTH-1]} - {2'b00, mag_b};
        div_next = div_diff[WIDTH+1] ? {acc[2*WIDTH-2:0], 1'b0}
                                     : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod     = neg_res ? -acc : acc;
        quot_fix = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = neg_res ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_val  = '0;
        if (spec_q) begin
            fix_val = acc[WIDTH-1:0];
        end else begin
            case (op_q)
                3'd0:                   fix_val = prod[WIDTH-1:0];
                3'd1, 3'd2, 3'd3:       fix_val = prod[2*WIDTH-1:WIDTH];
                3'd4, 3'd5:             fix_val = quot_fix;
                default:                fix_val = rem_fix;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; FIX can accept a new launch for gap-free back-to-back work.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) state_nxt = special ? FIX : CALC;
            end
            CALC: begin
                if (cnt == CW'(1)) state_nxt = FIX;
            end
            FIX: begin
                if (accept) state_nxt = special ? FIX : CALC;
                else        state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on launch, iterate in CALC, publish result from FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            op_q       <= '0;
            mag_a      <= '0;
            mag_b      <= '0;
            neg_res    <= 1'b0;
            spec_q     <= 1'b0;
            acc        <= '0;
            bus.done   <= 1'b0;
            bus.result <= '0;
        end else begin
            bus.done <= 1'b0;
            if (state == FIX) begin
                bus.result <= fix_val;
                bus.done   <= 1'b1;
            end
            if (accept) begin
                op_q    <= bus.op;
                mag_a   <= srca_mag;
                mag_b   <= srcb_mag;
                neg_res <= neg_nxt;
                spec_q  <= special;
                cnt     <= CW'(WIDTH);
                if (special) begin
                    acc <= {{WIDTH{1'b0}}, preset};
                end else if (bus.op[2]) begin
                    acc <= {{WIDTH{1'b0}}, srca_mag};
                end else begin
                    acc <= {{WIDTH{1'b0}}, srcb_mag};
                end
            end else if (state == CALC) begin
                cnt <= cnt - CW'(1);
                acc <= op_q[2] ? div_next : mul_next;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: 32-bit vector table, handshake sequences,
// and an 8-bit instance swept against a behavioural reference.
module tb_muldiv_unit;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg32, dbg8;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) if32 ();
    muldiv_if #(.WIDTH(8))  if8  ();

    muldiv_unit #(.WIDTH(32)) u32 (.clk(clk), .rst(rst), .bus(if32.slave), .dbg_state(dbg32));
    muldiv_unit #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(if8.slave),  .dbg_state(dbg8));

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        bit          spec;
    } vec32_t;

    vec32_t v32_q[$];

    task automatic add32(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input bit spec);
        vec32_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp; v.spec = spec;
        v32_q.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Launch one 32-bit op and wait for done; operands are scrambled after acceptance.
    task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat, output int busy_n,
                         output logic busy_at_done);
        @(negedge clk);
        if32.start = 1'b1; if32.op = op; if32.srca = a; if32.srcb = b;
        @(posedge clk); #1;
        if32.start = 1'b0;
        if32.op    = 3'($urandom_range(0, 7));
        if32.srca  = $urandom;
        if32.srcb  = $urandom;
        lat = -1; busy_n = 0; res = '0; busy_at_done = 1'b1;
        for (int c = 0; c <= 200; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (if32.done) begin
                lat = c; res = if32.result; busy_at_done = if32.busy;
                break;
            end
            if (if32.busy) busy_n++;
        end
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        output logic [7:0] res, output int lat);
        @(negedge clk);
        if8.start = 1'b1; if8.op = op; if8.srca = a; if8.srcb = b;
        @(posedge clk); #1;
        if8.start = 1'b0;
        if8.srca  = 8'($urandom);
        if8.srcb  = 8'($urandom);
        lat = -1; res = '0;
        for (int c = 0; c <= 50; c++) begin
            if (c > 0) begin @(posedge clk); #1; end
            if (if8.done) begin
                lat = c; res = if8.result;
                break;
            end
        end
    endtask

    // Behavioural RV32M reference scaled to 8 bits.
    function automatic logic [7:0] ref8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int  sa, sb, ua, ub, p;
        bit  ovf;
        sa  = $signed(a); sb = $signed(b); ua = a; ub = b;
        ovf = (a == 8'h80) && (b == 8'hFF);
        p   = 0;
        case (op)
            3'd0: begin p = ua * ub; return p[7:0];  end
            3'd1: begin p = sa * sb; return p[15:8]; end
            3'd2: begin p = sa * ub; return p[15:8]; end
            3'd3: begin p = ua * ub; return p[15:8]; end
            3'd4: begin
                if (b == 0) return 8'hFF;
                if (ovf)    return 8'h80;
                p = sa / sb; return p[7:0];
            end
            3'd5: begin
                if (b == 0) return 8'hFF;
                p = ua / ub; return p[7:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 8'h00;
                p = sa % sb; return p[7:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[7:0];
            end
        endcase
    endfunction

    initial begin
        logic [31:0] res, last_res;
        logic [7:0]  res8, exp8, a8, b8;
        logic [2:0]  op8;
        logic        bad;
        int          lat, busy_n, done_n, c;
        bit          spec8;

        rst = 1'b1;
        if32.start = 1'b0; if32.op = '0; if32.srca = '0; if32.srcb = '0;
        if8.start  = 1'b0; if8.op  = '0; if8.srca  = '0; if8.srcb  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy32",   32'(if32.busy),   32'd0);
        check("rst done32",   32'(if32.done),   32'd0);
        check("rst result32", if32.result,      32'd0);
        check("rst state32",  32'(dbg32),       32'd0);
        check("rst busy8",    32'(if8.busy),    32'd0);
        check("rst result8",  32'(if8.result),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        add32("mul 7*6",        3'd0, 32'd7,        32'd6,        32'd42,        1'b0);
        add32("mulh -1*-1",     3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000,  1'b0);
        add32("mulhu",          3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE,  1'b0);
        add32("mulhsu",         3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,  1'b0);
        add32("div -7/2",       3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD,  1'b0);
        add32("rem -7%2",       3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF,  1'b0);
        add32("divu",           3'd5, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC,  1'b0);
        add32("mul -3*5",       3'd0, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1,  1'b0);
        add32("mul shift",      3'd0, 32'h12345678, 32'h10,       32'h23456780,  1'b0);
        add32("mulhu 2^31*4",   3'd3, 32'h80000000, 32'd4,        32'h00000002,  1'b0);
        add32("mulhsu min*2",   3'd2, 32'h80000000, 32'd2,        32'hFFFFFFFF,  1'b0);
        add32("divu 100/7",     3'd5, 32'd100,      32'd7,        32'd14,        1'b0);
        add32("remu 100%7",     3'd7, 32'd100,      32'd7,        32'd2,         1'b0);
        add32("div 7/-2",       3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD,  1'b0);
        add32("rem 7%-2",       3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,         1'b0);
        add32("div by 0",       3'd4, 32'd55,       32'd0,        32'hFFFFFFFF,  1'b1);
        add32("remu by 0",      3'd7, 32'h1234,     32'd0,        32'h1234,      1'b1);
        add32("rem -7 by 0",    3'd6, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9,  1'b1);
        add32("div ovf",        3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1'b1);
        add32("rem ovf",        3'd6, 32'h80000000, 32'hFFFFFFFF, 32'h00000000,  1'b1);

        foreach (v32_q[i]) begin
            run32(v32_q[i].op, v32_q[i].a, v32_q[i].b, res, lat, busy_n, bad);
            check({v32_q[i].name, " result"},  res,           v32_q[i].exp);
            check({v32_q[i].name, " latency"}, 32'(lat),      v32_q[i].spec ? 32'd1 : 32'd33);
            check({v32_q[i].name, " busy"},    32'(busy_n),   v32_q[i].spec ? 32'd1 : 32'd33);
            check({v32_q[i].name, " busy@done"}, 32'(bad),    32'd0);
        end
        last_res = 32'h00000000;  // rem ovf is the final table entry

        // start pulsed mid-CALC must be dropped and must not queue.
        @(negedge clk);
        if32.start = 1'b1; if32.op = 3'd0; if32.srca = 32'd7; if32.srcb = 32'd6;
        @(posedge clk); #1;
        if32.start = 1'b0;
        lat = -1;
        for (c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (c == 10) begin
                if32.start = 1'b1; if32.op = 3'd4; if32.srca = 32'd100; if32.srcb = 32'd0;
            end
            if (c == 11) if32.start = 1'b0;
            if (c == 20) check("midcalc result held", if32.result, last_res);
            if (if32.done) begin lat = c; break; end
        end
        check("midcalc latency", 32'(lat), 32'd33);
        check("midcalc result",  if32.result, 32'd42);
        done_n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (if32.done) done_n++;
        end
        check("midcalc no extra done", 32'(done_n), 32'd0);
        check("midcalc idle", 32'(if32.busy), 32'd0);

        // start held high: launches accepted at E0, E33, E66 with no gap.
        @(negedge clk);
        if32.start = 1'b1; if32.op = 3'd0; if32.srca = 32'd3; if32.srcb = 32'd5;
        @(posedge clk); #1;
        if32.op = 3'd5; if32.srca = 32'd100; if32.srcb = 32'd7;
        for (c = 1; c <= 99; c++) begin
            @(posedge clk); #1;
            if (c == 33) begin
                check("b2b done1",   32'(if32.done), 32'd1);
                check("b2b result1", if32.result,    32'd15);
                check("b2b busy1",   32'(if32.busy), 32'd1);
                if32.op = 3'd6; if32.srca = 32'hFFFFFFF9; if32.srcb = 32'd2;
            end else if (c == 34) begin
                check("b2b single pulse", 32'(if32.done), 32'd0);
            end else if (c == 66) begin
                check("b2b done2",   32'(if32.done), 32'd1);
                check("b2b result2", if32.result,    32'd14);
                check("b2b busy2",   32'(if32.busy), 32'd1);
                if32.start = 1'b0;
            end else if (c == 99) begin
                check("b2b done3",   32'(if32.done), 32'd1);
                check("b2b result3", if32.result,    32'hFFFFFFFF);
                check("b2b busy3",   32'(if32.busy), 32'd0);
            end
        end

        // Reset at cycle 10 of a divide aborts it without a done.
        @(negedge clk);
        if32.start = 1'b1; if32.op = 3'd4; if32.srca = 32'd1000; if32.srcb = 32'd3;
        @(posedge clk); #1;
        if32.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort busy",   32'(if32.busy), 32'd0);
        check("abort done",   32'(if32.done), 32'd0);
        check("abort result", if32.result,    32'd0);
        check("abort state",  32'(dbg32),     32'd0);
        @(negedge clk);
        rst = 1'b0;
        done_n = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (if32.done) done_n++;
        end
        check("abort no stray done", 32'(done_n), 32'd0);

        // 8-bit instance: operand mix biased toward the special-case boundaries.
        for (int i = 0; i < 40; i++) begin
            op8 = 3'($urandom_range(0, 7));
            a8  = ($urandom_range(0, 3) == 0) ? 8'h80 : 8'($urandom);
            case ($urandom_range(0, 5))
                0:       b8 = 8'h00;
                1:       b8 = 8'hFF;
                default: b8 = 8'($urandom);
            endcase
            exp8  = ref8(op8, a8, b8);
            spec8 = op8[2] && ((b8 == 8'h00) ||
                    (!op8[0] && (a8 == 8'h80) && (b8 == 8'hFF)));
            run8(op8, a8, b8, res8, lat);
            check($sformatf("w8 op%0d %h,%h result", op8, a8, b8), 32'(res8), 32'(exp8));
            check($sformatf("w8 op%0d %h,%h latency", op8, a8, b8), 32'(lat), spec8 ? 32'd1 : 32'd9);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule
